// File: rtl/rank_pifo_if.sv
// Handshake bundle between the rank pipe / egress scheduler and the sorted PIFO array.
// The slave modport is the PIFO side; the master modport is the producer/consumer side.
interface rank_pifo_if #(
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 16,
    parameter int L2_DEPTH   = 4
);
    logic                  up_valid;
    logic [RANK_WIDTH-1:0] up_rank;
    logic [META_WIDTH-1:0] up_meta;
    logic                  up_remove;
    logic                  flush;
    logic                  deq_req;
    logic                  deq_valid;
    logic [RANK_WIDTH-1:0] deq_rank;
    logic [META_WIDTH-1:0] deq_meta;
    logic [L2_DEPTH:0]     count;
    logic                  full;

    modport master (
        output up_valid, up_rank, up_meta, flush, deq_req,
        input  up_remove, deq_valid, deq_rank, deq_meta, count, full
    );

    modport slave (
        input  up_valid, up_rank, up_meta, flush, deq_req,
        output up_remove, deq_valid, deq_rank, deq_meta, count, full
    );
endinterface

// File: rtl/rank_pifo.sv
// Register-based push-in/first-out queue sorted by ascending rank, ties kept in arrival order.
// Slot 0 is the head; one insert and one dequeue can happen in the same cycle.
module rank_pifo #(
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 16,
    parameter int L2_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    rank_pifo_if.slave  pif
);
    localparam int DEPTH = 2 ** L2_DEPTH;
    localparam int CW    = L2_DEPTH + 1;

    logic [DEPTH-1:0]      vld, vld_nxt, vld_dn, vld_up;
    logic [RANK_WIDTH-1:0] rank_q   [DEPTH];
    logic [RANK_WIDTH-1:0] rank_nxt [DEPTH];
    logic [RANK_WIDTH-1:0] rank_dn  [DEPTH];
    logic [RANK_WIDTH-1:0] rank_up  [DEPTH];
    logic [META_WIDTH-1:0] meta_q   [DEPTH];
    logic [META_WIDTH-1:0] meta_nxt [DEPTH];
    logic [META_WIDTH-1:0] meta_dn  [DEPTH];
    logic [META_WIDTH-1:0] meta_up  [DEPTH];
    logic [CW-1:0]         cnt, p, pos;
    logic                  full_w, pop, ins;

    assign full_w = (cnt == CW'(DEPTH));
    assign pop    = pif.deq_req & (cnt != '0) & ~pif.flush;
    // rst gate keeps the accept low while the array is held in reset
    assign ins    = pif.up_valid & ~pif.flush & rst & (~full_w | pop);

    // Counting every slot with rank <= new rank puts ties behind existing equals.
    always_comb begin
        p = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (rank_q[i] <= pif.up_rank)) p = p + 1'b1;
        end
    end

    // With a concurrent pop the head leaves, so the landing slot moves down by one.
    assign pos = (pop && (p != '0)) ? p - 1'b1 : p;

    assign vld_dn = {1'b0, vld[DEPTH-1:1]};
    assign vld_up = {vld[DEPTH-2:0], 1'b0};

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            rank_dn[i] = rank_q[i+1];
            meta_dn[i] = meta_q[i+1];
        end
        rank_dn[DEPTH-1] = '0;
        meta_dn[DEPTH-1] = '0;
        rank_up[0] = '0;
        meta_up[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            rank_up[i] = rank_q[i-1];
            meta_up[i] = meta_q[i-1];
        end
    end

    always_comb begin
        vld_nxt  = vld;
        rank_nxt = rank_q;
        meta_nxt = meta_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ins && pop) begin
                if (CW'(i) < pos) begin
                    vld_nxt[i]  = vld_dn[i];
                    rank_nxt[i] = rank_dn[i];
                    meta_nxt[i] = meta_dn[i];
                end else if (CW'(i) == pos) begin
                    vld_nxt[i]  = 1'b1;
                    rank_nxt[i] = pif.up_rank;
                    meta_nxt[i] = pif.up_meta;
                end
            end else if (ins) begin
                if (CW'(i) == pos) begin
                    vld_nxt[i]  = 1'b1;
                    rank_nxt[i] = pif.up_rank;
                    meta_nxt[i] = pif.up_meta;
                end else if (CW'(i) > pos) begin
                    vld_nxt[i]  = vld_up[i];
                    rank_nxt[i] = rank_up[i];
                    meta_nxt[i] = meta_up[i];
                end
            end else if (pop) begin
                vld_nxt[i]  = vld_dn[i];
                rank_nxt[i] = rank_dn[i];
                meta_nxt[i] = meta_dn[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rank_q[i] <= '0;
                meta_q[i] <= '0;
            end
        end else if (pif.flush) begin
            vld <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rank_q[i] <= '0;
                meta_q[i] <= '0;
            end
        end else begin
            vld    <= vld_nxt;
            rank_q <= rank_nxt;
            meta_q <= meta_nxt;
            if (ins && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !ins) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign pif.up_remove = ins;
    assign pif.deq_valid = (cnt != '0);
    assign pif.deq_rank  = rank_q[0];
    assign pif.deq_meta  = meta_q[0];
    assign pif.count     = cnt;
    assign pif.full      = full_w;
endmodule

// File: tb/tb_rank_pifo.sv
// Randomized and directed checks of rank_pifo against a sorted-queue reference model.
module tb_rank_pifo;
    localparam int RW = 16;
    localparam int MW = 16;
    localparam int L2 = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rank_pifo_if #(.RANK_WIDTH(RW), .META_WIDTH(MW), .L2_DEPTH(L2)) pif ();

    rank_pifo #(.RANK_WIDTH(RW), .META_WIDTH(MW), .L2_DEPTH(L2)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    typedef struct {
        logic [RW-1:0] rank;
        logic [MW-1:0] meta;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;
    logic [MW-1:0] meta_seq = 16'h0100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: pop the head first, then place the new entry after every rank <= it.
    function automatic void model_apply(input logic uv, input logic [RW-1:0] ur,
                                        input logic [MW-1:0] um, input logic fl, input logic dr);
        int  n;
        bit  do_pop, do_ins;
        ent_t e;
        if (fl) begin
            mq.delete();
            return;
        end
        do_pop = dr && (mq.size() > 0);
        do_ins = uv && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_ins) begin
            n = 0;
            foreach (mq[i]) if (mq[i].rank <= ur) n = i + 1;
            e.rank = ur;
            e.meta = um;
            mq.insert(n, e);
        end
    endfunction

    function automatic logic exp_remove(input logic uv, input logic fl, input logic dr);
        return uv && !fl && ((mq.size() < DEPTH) || (dr && mq.size() > 0));
    endfunction

    task automatic step(input logic uv, input logic [RW-1:0] ur, input logic [MW-1:0] um,
                        input logic fl, input logic dr);
        pif.up_valid = uv;
        pif.up_rank  = ur;
        pif.up_meta  = um;
        pif.flush    = fl;
        pif.deq_req  = dr;
        #2;
        check("up_remove", 32'(pif.up_remove), 32'(exp_remove(uv, fl, dr)));
        check("count",     32'(pif.count),     32'(mq.size()));
        check("deq_valid", 32'(pif.deq_valid), 32'(mq.size() > 0));
        check("full",      32'(pif.full),      32'(mq.size() == DEPTH));
        check("deq_rank",  32'(pif.deq_rank),  (mq.size() > 0) ? 32'(mq[0].rank) : 32'd0);
        check("deq_meta",  32'(pif.deq_meta),  (mq.size() > 0) ? 32'(mq[0].meta) : 32'd0);
        @(posedge clk);
        model_apply(uv, ur, um, fl, dr);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic ins(input logic [RW-1:0] r, input logic [MW-1:0] m);
        step(1'b1, r, m, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_flush();
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        pif.up_valid = 1'b0;
        pif.up_rank  = '0;
        pif.up_meta  = '0;
        pif.flush    = 1'b0;
        pif.deq_req  = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // reset mid-stream with 5 entries loaded
        for (int i = 0; i < 5; i++) ins(16'(50 - i), 16'(i + 1));
        idle();
        #1 rst = 1'b0;
        mq.delete();
        #1;
        check("rst_count",     32'(pif.count),     32'd0);
        check("rst_deq_valid", 32'(pif.deq_valid), 32'd0);
        check("rst_deq_rank",  32'(pif.deq_rank),  32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        idle();
        check("post_rst_count", 32'(pif.count), 32'd0);

        // sorting: 40,10,30,20 -> pops 10,20,30,40 meta 2,4,3,1
        ins(16'd40, 16'd1);
        ins(16'd10, 16'd2);
        ins(16'd30, 16'd3);
        ins(16'd20, 16'd4);
        check("sort_head", 32'(pif.deq_rank), 32'd10);
        pop(); pop(); pop(); pop();
        idle();

        // tie FIFO on rank 7
        ins(16'd7, 16'h000A);
        ins(16'd7, 16'h000B);
        ins(16'd7, 16'h000C);
        check("tie_head_meta", 32'(pif.deq_meta), 32'h000A);
        pop(); pop(); pop();
        idle();

        // full backpressure, then insert-with-pop while full
        for (int i = 16; i >= 1; i--) ins(16'(i), 16'(16'h0200 + i));
        #2;
        check("full_flag",  32'(pif.full),  32'd1);
        check("full_count", 32'(pif.count), 32'd16);
        step(1'b1, 16'd0, 16'h0300, 1'b0, 1'b0);
        step(1'b1, 16'd0, 16'h0300, 1'b0, 1'b1);
        idle();
        #2;
        check("full_swap_head",  32'(pif.deq_rank), 32'd0);
        check("full_swap_count", 32'(pif.count),    32'd16);
        ins(16'hFFFF, 16'h0400);
        step(1'b1, 16'hFFFF, 16'h0401, 1'b0, 1'b1);
        do_flush();

        // simultaneous insert and pop
        ins(16'd5, 16'd1);
        ins(16'd9, 16'd2);
        ins(16'd12, 16'd3);
        step(1'b1, 16'd8, 16'd4, 1'b0, 1'b1);
        step(1'b1, 16'd3, 16'd5, 1'b0, 1'b1);
        idle();
        #2;
        check("simul_head", 32'(pif.deq_rank), 32'd3);
        do_flush();

        // empty insert with deq_req: no pop, lands at slot 0
        step(1'b1, 16'd77, 16'd9, 1'b0, 1'b1);
        do_flush();

        // flush with up_valid high, then pop while empty
        for (int i = 0; i < 6; i++) ins(16'(i * 3), 16'(i));
        step(1'b1, 16'd1, 16'd1, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle();

        // randomized mix
        for (int n = 0; n < 1500; n++) begin
            logic          uv, dr, fl;
            logic [RW-1:0] r;
            uv = ($urandom_range(0, 99) < 65);
            dr = ($urandom_range(0, 99) < 40);
            fl = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0:       r = 16'($urandom_range(0, 7));
                1:       r = 16'hFFFF;
                default: r = 16'($urandom);
            endcase
            meta_seq = meta_seq + 1'b1;
            step(uv, r, meta_seq, fl, dr);
        end
        while (mq.size() > 0) pop();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rank_pifo.md
Name: rank_pifo

Overview:
- Downstream consumer of the rank computation pipe: drains its (rank, meta) output whenever space exists.
- Holds entries in a register-based sorted array, ordered by ascending rank; ties are kept in FIFO order.
- Presents the minimum-rank entry to the egress scheduler and supports push-in/first-out with one insert and one dequeue per cycle.

Parameters:
- RANK_WIDTH, 16, rank field width (matches rank pipe output)
- META_WIDTH, 16, metadata width carried with each rank
- L2_DEPTH, 4, log2 of entry count (DEPTH = 2**L2_DEPTH = 16)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- up_valid  input  1  rank pipe has an entry available (its valid_out)
- up_rank  input  RANK_WIDTH  rank of the offered entry
- up_meta  input  META_WIDTH  metadata of the offered entry
- up_remove  output  1  combinational accept; drives the rank pipe remove
- flush  input  1  synchronous clear of all entries
- deq_req  input  1  egress requests a pop of the head
- deq_valid  output  1  head entry valid (array non-empty)
- deq_rank  output  RANK_WIDTH  head rank; 0 when empty
- deq_meta  output  META_WIDTH  head metadata; 0 when empty
- count  output  L2_DEPTH+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH

Behaviour:
- Storage: DEPTH slots, each {vld, rank, meta}. Slot 0 is the head. Valid slots are contiguous from 0 and sorted non-decreasing by rank.

Reset and flush:
- rst low (async): every vld=0 and every rank/meta=0. count=0, deq_valid=0, deq_rank=0, deq_meta=0, full=0, up_remove=0.
- Reset mid-operation discards all contents; nothing is emitted after release until new inserts arrive.
- flush=1: same clearing on the next clk edge. up_remove is forced 0 while flush=1, and deq pops are ignored.

Handshakes:
- pop = deq_req & deq_valid. deq_req while empty is ignored, with no state change.
- up_remove = up_valid & ~flush & (~full | pop). This is combinational, so an entry is consumed in the same cycle it is offered.

Insert placement:
- Compare the new rank against every slot in parallel: gt[i] = vld[i] & (rank[i] <= new_rank). Comparison is unsigned.
- Insert position p = number of set gt bits. This places ties after existing equal ranks, giving FIFO among ties.
- Slots i >= p shift up by one; the new entry is written into slot p.

Dequeue:
- All slots shift down by one; the top slot is cleared.

Simultaneous insert and pop:
- Net count is unchanged.
- The new entry is written at slot p-1 when p>0, or at slot 0 when p=0 (the new entry becomes the head).
- Slots below the insertion point shift down; slots above it hold.
- Legal when full: the popped head frees space.

Latency and outputs:
- An entry accepted in cycle N is visible at the head in cycle N+1 if it is the minimum.
- The head outputs come straight from slot 0 registers (zero-cycle read). After a pop in cycle N, the new head appears in cycle N+1.
- count updates on the edge: +1 on insert only, -1 on pop only, unchanged on both or neither.
- full and deq_valid are derived from count (registered state).

Boundaries:
- Full without a pop: up_remove=0, so the rank pipe holds its entry and nothing is dropped.
- Empty with an insert and deq_req in the same cycle: no pop (deq_valid=0), and the insert lands at slot 0.
- Maximum rank 0xFFFF sorts last. Equal ranks preserve arrival order.

Test Plan:
- Reset: hold rst=0 mid-stream with 5 entries loaded, then release -> count=0, deq_valid=0, deq_rank=0, up_remove=0 on the first cycle after release.
- Sorting: insert ranks 40, 10, 30, 20 (meta 1..4) on consecutive cycles -> head sequence 40, 10, 10, 10. Then pop 4 times -> deq_rank 10, 20, 30, 40 with meta 2, 4, 3, 1.
- Tie FIFO: insert rank 7 with meta A, B, C -> pops return meta A, B, C in order.
- Full backpressure: insert 16 entries with ranks 16..1 -> full=1, count=16. With up_valid=1 rank 0 offered, up_remove=0 and contents are unchanged. Assert deq_req -> up_remove=1 that cycle; next cycle head rank=0, count=16.
- Simultaneous insert and pop: contents {5, 9, 12}; insert 8 and pop in the same cycle -> contents {8, 9, 12}, count=3. Repeat with insert 3 -> head 3.
- Flush and empty pop: with 6 entries loaded, pulse flush with up_valid=1 -> up_remove=0 and count=0 next cycle. deq_req while empty -> no change, deq_valid stays 0.
